// File: rtl/fifo_stream_drain.sv
// rtl/fifo_stream_drain.sv - drains a registered-read FIFO into a packetised valid/ready stream
module fifo_stream_drain #(
   parameter int WIDTH   = 8,
   parameter int PKT_LEN = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [15:0]      pkt_count
);

   localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

   logic [WIDTH-1:0] mem [0:2];
   logic [1:0]       head;
   logic [1:0]       tail;
   logic [1:0]       occ;
   logic             in_flight;
   logic [BW-1:0]    beat;
   logic             push;
   logic             pop;

   function automatic logic [1:0] ptr_next(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Reads are issued only when a slot is guaranteed for the returning word,
   // so the read request never looks at m_ready.
   always_comb begin
      fifo_rd_en = !reset && !fifo_empty && (({1'b0, occ} + {2'b00, in_flight}) < 3'd3);
      m_valid    = !reset && (occ != 2'd0);
      m_data     = reset ? '0 : mem[head];
      m_last     = m_valid && (beat == LAST_BEAT);
      push       = in_flight;
      pop        = m_valid && m_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            mem[i] <= '0;
         end
         head      <= 2'd0;
         tail      <= 2'd0;
         occ       <= 2'd0;
         in_flight <= 1'b0;
         beat      <= '0;
         pkt_count <= 16'd0;
      end else begin
         in_flight <= fifo_rd_en;
         if (push) begin
            mem[tail] <= fifo_data;
            tail      <= ptr_next(tail);
         end
         if (pop) begin
            head <= ptr_next(head);
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            if (m_last) begin
               pkt_count <= pkt_count + 16'd1;
            end
         end
         unique case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb/tb_fifo_stream_drain.sv - scoreboard bench for fifo_stream_drain
module tb_fifo_stream_drain;
   localparam int W  = 8;
   localparam int PL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset = 1'b1;
   logic         fifo_empty = 1'b1, fifo_empty2 = 1'b1;
   logic [W-1:0] fifo_data = '0, fifo_data2 = '0;
   logic         fifo_rd_en, rd_en2;
   logic         m_valid, m_valid2, m_last, m_last2;
   logic         m_ready = 1'b0, m_ready2 = 1'b1;
   logic [W-1:0] m_data, m_data2;
   logic [15:0]  pkt_count, pkt_count2;

   fifo_stream_drain #(.WIDTH(W), .PKT_LEN(PL)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .pkt_count(pkt_count));

   fifo_stream_drain #(.WIDTH(W), .PKT_LEN(1)) dut1 (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
      .fifo_rd_en(rd_en2), .m_valid(m_valid2), .m_ready(m_ready2),
      .m_data(m_data2), .m_last(m_last2), .pkt_count(pkt_count2));

   int           tests = 0, fails = 0;
   logic [W-1:0] src_q[$], exp_q[$], src2_q[$], exp2_q[$];
   int           hs = 0, hs2 = 0, exp_pkt = 0;
   bit           rand_ready = 1'b0;
   logic         s_rd, s_v, s_rd2;
   logic [W-1:0] s_d;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Upstream FIFO models: a read accepted at an edge presents its word after that edge.
   task automatic tick();
      @(negedge clk);
      s_rd  = fifo_rd_en;
      s_v   = m_valid;
      s_d   = m_data;
      s_rd2 = rd_en2;
      @(posedge clk);
      #1;
      if (s_rd && src_q.size() > 0)   fifo_data  = src_q.pop_front();
      if (s_rd2 && src2_q.size() > 0) fifo_data2 = src2_q.pop_front();
      fifo_empty  = (src_q.size() == 0);
      fifo_empty2 = (src2_q.size() == 0);
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push_word(input logic [W-1:0] w);
      src_q.push_back(w);
      exp_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   // Whatever the block had already fetched is lost; the FIFO remainder is what comes next.
   task automatic start_reset();
      reset  = 1'b1;
      exp_q  = src_q;
      exp2_q = src2_q;
   endtask

   task automatic wait_hs(input string name, input int target, input int budget);
      int k = 0;
      while (hs < target && k < budget) begin
         tick();
         k++;
      end
      chk(name, hs, target);
   endtask

   // Monitor: expected framing comes from the handshake index since reset.
   logic         prev_stall = 1'b0, prev_l = 1'b0;
   logic [W-1:0] prev_d = '0;
   always @(negedge clk) begin
      if (reset) begin
         hs      = 0;
         hs2     = 0;
         exp_pkt = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_d);
            chk("stall_last", m_last, prev_l);
         end
         chk("pkt_count", pkt_count, exp_pkt);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 1, 0);
            end else begin
               chk("data", m_data, exp_q.pop_front());
            end
            chk("last", m_last, (hs % PL) == PL - 1);
            if ((hs % PL) == PL - 1) exp_pkt = (exp_pkt + 1) % 65536;
            hs++;
         end
         if (m_valid2 && m_ready2) begin
            if (exp2_q.size() == 0) begin
               chk("unexpected_word1", 1, 0);
            end else begin
               chk("data1", m_data2, exp2_q.pop_front());
            end
            chk("last1", m_last2, 1);
            hs2++;
         end
      end
      prev_stall = !reset && m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
   end

   initial begin
      int nrd;
      int n_rem;
      int k;

      // reset holds everything quiet even with data waiting
      src_q.push_back(8'hAA);
      fifo_empty = 1'b0;
      repeat (2) begin
         tick();
         chk("rst_rd_en", s_rd, 0);
         chk("rst_valid", s_v, 0);
         chk("rst_data", s_d, 0);
         chk("rst_pkt", pkt_count, 0);
      end
      src_q.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
      reset = 1'b0;
      m_ready = 1'b1;
      tick();

      // latency and streaming
      for (int i = 1; i <= 8; i++) push_word(W'(i));
      tick(); chk("lat_c0", s_v, 0);
      tick(); chk("lat_c1", s_v, 0);
      tick(); chk("lat_c2", s_v, 1);
      repeat (7) begin
         tick();
         chk("stream_valid", s_v, 1);
      end
      chk("stream_hs", hs, 8);
      chk("stream_pkt", pkt_count, 2);

      // backpressure
      start_reset();
      tick();
      reset = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) push_word(W'(8'h10 + i));
      nrd = 0;
      repeat (10) begin
         tick();
         nrd += int'(s_rd);
      end
      chk("bp_reads", nrd, 3);
      chk("bp_rd_idle", s_rd, 0);
      chk("bp_head", s_d, 8'h10);
      chk("bp_valid", s_v, 1);
      m_ready = 1'b1;
      repeat (16) tick();
      chk("bp_no_gaps", hs, 16);
      chk("bp_pkt", pkt_count, 4);

      // random words, random backpressure
      start_reset();
      tick();
      reset = 1'b0;
      rand_ready = 1'b1;
      for (int i = 0; i < 1000; i++) push_word(W'($urandom));
      wait_hs("rand_hs", 1000, 6000);
      rand_ready = 1'b0;
      m_ready = 1'b1;
      tick();
      chk("rand_pkt", pkt_count, 250);

      // reset in the middle of a packet
      start_reset();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) push_word(W'(8'h30 + i));
      wait_hs("mid_pre_hs", 2, 50);
      tick();
      start_reset();
      n_rem = src_q.size();
      tick();
      chk("mid_rst_valid", s_v, 0);
      chk("mid_rst_rd", s_rd, 0);
      reset = 1'b0;
      wait_hs("mid_post_hs", n_rem, 100);
      tick();
      chk("mid_pkt", pkt_count, n_rem / PL);

      // single-word packets
      for (int i = 0; i < 5; i++) begin
         src2_q.push_back(W'(8'h50 + i));
         exp2_q.push_back(W'(8'h50 + i));
      end
      fifo_empty2 = 1'b0;
      k = 0;
      while (hs2 < 5 && k < 50) begin
         tick();
         k++;
      end
      chk("len1_hs", hs2, 5);
      tick();
      chk("len1_pkt", pkt_count2, 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fifo_stream_drain.md
FIFO_STREAM_DRAIN -- requirements
Module: fifo_stream_drain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter PKT_LEN, default 4, giving the number of words per packet (legal range 1..256).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port fifo_empty, input, 1: upstream FIFO empty flag.
REQ-006 Port fifo_data, input, WIDTH: upstream FIFO registered read data, valid in the cycle after an accepted read.
REQ-007 Port fifo_rd_en, output, 1: read request to upstream FIFO.
REQ-008 Port m_valid, output, 1: downstream word available.
REQ-009 Port m_ready, input, 1: downstream accepts word.
REQ-010 Port m_data, output, WIDTH: downstream word.
REQ-011 Port m_last, output, 1: marks the final word of a packet.
REQ-012 Port pkt_count, output, 16: number of completed packets.

Function
REQ-013 The block SHALL contain a 3-entry in-order skid buffer (occupancy 0..3), an in-flight flag and a beat counter.
REQ-014 fifo_rd_en SHALL be asserted iff reset=0, fifo_empty=0 and (occupancy + in-flight) < 3.
REQ-015 fifo_rd_en SHALL have no combinational dependence on m_ready.
REQ-016 The in-flight flag SHALL be set on an edge where fifo_rd_en=1 and cleared otherwise.
REQ-017 When the in-flight flag is 1, fifo_data SHALL be written into the buffer tail on the next edge.
REQ-018 m_valid SHALL equal (occupancy != 0), and m_data SHALL be the buffer head word.
REQ-019 A transfer (handshake) SHALL occur on an edge where m_valid=1 and m_ready=1; the handshake pops the head.
REQ-020 A push and a pop on the same edge SHALL leave occupancy unchanged and preserve word order.
REQ-021 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-022 Latency: when fifo_empty falls in cycle c with the buffer empty and nothing in flight, m_valid SHALL rise in cycle c+2.
REQ-023 With fifo_empty=0 and m_ready=1 held, the block SHALL sustain one handshake per cycle after the initial latency.
REQ-024 The buffer SHALL never overflow: occupancy + in-flight <= 3 at all times.
REQ-025 The beat counter SHALL have range 0..PKT_LEN-1, increment on each handshake, and wrap to 0 after the handshake at PKT_LEN-1.
REQ-026 m_last SHALL equal m_valid AND (beat counter == PKT_LEN-1); with PKT_LEN=1, every word SHALL be last.
REQ-027 pkt_count SHALL increment by 1 on each handshake with m_last=1, wrapping from 65535 to 0.
REQ-028 No word from the FIFO SHALL be dropped, duplicated or reordered outside of reset.

Reset
REQ-029 While reset=1, on each edge: occupancy=0, in-flight=0, beat counter=0, pkt_count=0, and buffer storage cleared to 0.
REQ-030 While reset=1: fifo_rd_en=0, m_valid=0, m_last=0 and m_data=0.
REQ-031 Reset asserted mid-operation SHALL discard buffered and in-flight words and restart the packet boundary at beat 0.
REQ-032 The first edge with reset=0 SHALL behave as from the empty state.

Verification
REQ-033 Reset: hold reset=1 for 2 cycles with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0, pkt_count=0.
REQ-034 Latency/streaming: FIFO preloaded with 0x01..0x08, m_ready=1 -> m_valid rises 2 cycles after fifo_empty falls, then words 0x01..0x08 appear on consecutive cycles; m_last=1 on 0x04 and 0x08; pkt_count=2.
REQ-035 Backpressure: FIFO preloaded with 0x10..0x1F, m_ready=0 for 10 cycles -> exactly 3 reads are issued; fifo_rd_en stays 0 afterwards; m_data holds 0x10. Then m_ready=1 -> all 16 words in order, no gaps while the FIFO is non-empty.
REQ-036 Random m_ready (50%) over 1000 random words -> output sequence equals input sequence; m_last on every 4th handshake; pkt_count=250.
REQ-037 Mid-stream reset: assert reset 1 cycle after the 2nd handshake of a packet -> m_valid=0 and beat counter 0. The next word after release is beat 0, with m_last=1 on the 4th subsequent word.
REQ-038 PKT_LEN=1 build: 5 words -> m_last=1 on all 5 handshakes; pkt_count=5.
